// File: rtl/c2f_chunk_buffer_if.sv
// Bus bundle between the C2F chunk buffer, the TLP receiver (writes/doorbell)
// and the checksum consumer (reads/ack).
interface c2f_chunk_buffer_if #(
  parameter int unsigned NUM_CHUNKS   = 4,
  parameter int unsigned CHUNK_QWORDS = 16
);
  localparam int unsigned IDX_W = $clog2(NUM_CHUNKS);
  localparam int unsigned OFF_W = $clog2(CHUNK_QWORDS);

  logic             wrValid_in;
  logic [IDX_W-1:0] wrChunk_in;
  logic [OFF_W-1:0] wrOffset_in;
  logic [63:0]      wrData_in;
  logic             dbValid_in;
  logic [IDX_W-1:0] wrIndex_out;
  logic [IDX_W-1:0] rdIndex_out;
  logic             dtAck_in;
  logic [OFF_W-1:0] rdOffset_in;
  logic [63:0]      rdData_out;
  logic             ovfErr_out;
  logic             udfErr_out;
  logic             wrErr_out;
  logic             fillErr_out;

  modport master (
    output wrValid_in, wrChunk_in, wrOffset_in, wrData_in, dbValid_in,
    output dtAck_in, rdOffset_in,
    input  wrIndex_out, rdIndex_out, rdData_out,
    input  ovfErr_out, udfErr_out, wrErr_out, fillErr_out
  );

  modport slave (
    input  wrValid_in, wrChunk_in, wrOffset_in, wrData_in, dbValid_in,
    input  dtAck_in, rdOffset_in,
    output wrIndex_out, rdIndex_out, rdData_out,
    output ovfErr_out, udfErr_out, wrErr_out, fillErr_out
  );
endinterface

// File: rtl/c2f_chunk_buffer.sv
// CPU-to-FPGA chunk ring buffer feeding the C2F checksum consumer.
// Optional per-chunk completeness check on doorbell: define C2F_FILL_CHECK_EN.
module c2f_chunk_buffer #(
  parameter int unsigned NUM_CHUNKS   = 4,
  parameter int unsigned CHUNK_QWORDS = 16
) (
  input  logic              sysClk_in,
  input  logic              sysRst_in,
  c2f_chunk_buffer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_CHUNKS);
  localparam int unsigned OFF_W = $clog2(CHUNK_QWORDS);
  localparam int unsigned DEPTH = NUM_CHUNKS * CHUNK_QWORDS;

  logic [IDX_W-1:0] wrIndex;
  logic [IDX_W-1:0] rdIndex;
  logic [IDX_W-1:0] occ;
  logic [IDX_W-1:0] wrRel;
  logic             empty;
  logic             full;
  logic             ackOk;
  logic             wrOk;
  logic             dbRoom;
  logic             dbOk;
  logic             fillOk;
  logic             ovfErr;
  logic             udfErr;
  logic             wrErr;
  logic             fillErr;
  logic [63:0]      rdData;
  logic [63:0]      mem [DEPTH];

  // Ring bookkeeping; a chunk is consumer-owned when it lies in [rdIndex, wrIndex)
  always_comb begin
    occ    = wrIndex - rdIndex;
    wrRel  = bus.wrChunk_in - rdIndex;
    empty  = (occ == '0);
    full   = (occ == IDX_W'(NUM_CHUNKS - 1));
    ackOk  = bus.dtAck_in && !empty;
    wrOk   = bus.wrValid_in && (wrRel >= occ);
    dbRoom = !full || ackOk;
    dbOk   = bus.dbValid_in && dbRoom && fillOk;
  end

  always_ff @(posedge sysClk_in or posedge sysRst_in) begin
    if (sysRst_in) begin
      wrIndex <= '0;
      rdIndex <= '0;
      ovfErr  <= 1'b0;
      udfErr  <= 1'b0;
      wrErr   <= 1'b0;
      rdData  <= '0;
    end else begin
      if (ackOk)                         rdIndex <= rdIndex + IDX_W'(1);
      if (dbOk)                          wrIndex <= wrIndex + IDX_W'(1);
      if (bus.dbValid_in && !dbRoom)     ovfErr  <= 1'b1;
      if (bus.dtAck_in && empty)         udfErr  <= 1'b1;
      if (bus.wrValid_in && !wrOk)       wrErr   <= 1'b1;
      rdData <= mem[{rdIndex, bus.rdOffset_in}];
    end
  end

  // Chunk RAM, intentionally not reset
  always_ff @(posedge sysClk_in) begin
    if (wrOk) mem[{bus.wrChunk_in, bus.wrOffset_in}] <= bus.wrData_in;
  end

`ifdef C2F_FILL_CHECK_EN
  logic [CHUNK_QWORDS-1:0] fillMap [NUM_CHUNKS];

  assign fillOk = &fillMap[wrIndex];

  // Per-chunk written-QW bitmap; cleared when the chunk is handed to the consumer
  always_ff @(posedge sysClk_in or posedge sysRst_in) begin
    if (sysRst_in) begin
      for (int i = 0; i < NUM_CHUNKS; i++) fillMap[i] <= '0;
      fillErr <= 1'b0;
    end else begin
      if (dbOk) fillMap[wrIndex] <= '0;
      if (wrOk) fillMap[bus.wrChunk_in][bus.wrOffset_in] <= 1'b1;
      if (bus.dbValid_in && dbRoom && !fillOk) fillErr <= 1'b1;
    end
  end
`else
  assign fillOk  = 1'b1;
  assign fillErr = 1'b0;
`endif

  assign bus.wrIndex_out = wrIndex;
  assign bus.rdIndex_out = rdIndex;
  assign bus.rdData_out  = rdData;
  assign bus.ovfErr_out  = ovfErr;
  assign bus.udfErr_out  = udfErr;
  assign bus.wrErr_out   = wrErr;
  assign bus.fillErr_out = fillErr;
endmodule

// File: doc/c2f_chunk_buffer.md
Name: c2f_chunk_buffer

Overview:
- CPU-to-FPGA chunk ring buffer that sits directly upstream of the C2F checksum consumer.
- Accepts QW writes decoded by the TLP receiver into a RAM of NUM_CHUNKS chunks.
- Commits chunks on a CPU doorbell and publishes wrIndex/rdIndex to the consumer.
- Serves the consumer's 1-cycle-latency QW reads and retires a chunk on dtAck.

Parameters:
- NUM_CHUNKS, 4, ring depth in chunks; power of 2, >=2; IDX_W = $clog2(NUM_CHUNKS).
- CHUNK_QWORDS, 16, 64-bit words per chunk (C2F_CHUNKSIZE/8); power of 2; OFF_W = $clog2(CHUNK_QWORDS).

Ports:
- sysClk_in  in  1  system clock; all logic on its rising edge.
- sysRst_in  in  1  asynchronous, active-high reset.
- wrValid_in  in  1  QW write strobe from the TLP receiver.
- wrChunk_in  in  IDX_W  chunk number of the write.
- wrOffset_in  in  OFF_W  QW offset within the chunk.
- wrData_in  in  64  QW write data.
- dbValid_in  in  1  doorbell: commit chunk wrIndex, 1-cycle pulse.
- wrIndex_out  out  IDX_W  producer index; next chunk to be committed.
- rdIndex_out  out  IDX_W  consumer index; oldest committed chunk.
- dtAck_in  in  1  consumer finished chunk rdIndex, 1-cycle pulse.
- rdOffset_in  in  OFF_W  consumer read offset within chunk rdIndex.
- rdData_out  out  64  QW at {rdIndex, rdOffset_in}, registered.
- ovfErr_out  out  1  sticky: doorbell rejected because the ring was full.
- udfErr_out  out  1  sticky: dtAck received while the ring was empty.
- wrErr_out  out  1  sticky: write to a committed chunk was rejected.
- fillErr_out  out  1  sticky: incomplete-chunk doorbell (optional feature only).

Behaviour:
- Reset (async assert, sync release): wrIndex = rdIndex = 0, rdData_out = 0, all error flags = 0. RAM contents are not reset.
- Occupancy: occ = (wrIndex - rdIndex) mod NUM_CHUNKS.
  - empty: occ == 0; full: occ == NUM_CHUNKS-1.
  - Capacity is NUM_CHUNKS-1 chunks, because wrIndex == rdIndex always means empty.
- Owned chunks: chunks rdIndex .. wrIndex-1 (mod) are owned by the consumer. All other chunks are writable.
- Write: on wrValid_in, if wrChunk_in is not owned (using pre-edge indices), RAM[{wrChunk_in, wrOffset_in}] <= wrData_in.
  - Otherwise the write is dropped and wrErr_out is set.
  - A write to a chunk released by a dtAck in the same cycle is still rejected.
- Doorbell: on dbValid_in, if not full, wrIndex <= wrIndex+1 (wraps NUM_CHUNKS-1 -> 0).
  - If full, wrIndex holds and ovfErr_out is set.
  - Exception: when full and dtAck_in is accepted in the same cycle, the doorbell is accepted.
- Ack: on dtAck_in, if not empty (pre-edge), rdIndex <= rdIndex+1 (wraps).
  - If empty, rdIndex holds and udfErr_out is set, even if a doorbell lands in the same cycle.
- Simultaneous accepted doorbell and ack: both indices advance; occupancy is unchanged.
- Read: rdData_out <= RAM[{rdIndex, rdOffset_in}] each cycle, so data appears 1 cycle after rdOffset_in is presented.
  - The read uses pre-edge rdIndex; the cycle of a dtAck still reads the old chunk.
  - No read/write collision is possible, because chunk rdIndex is owned whenever the consumer reads it.
- Index outputs are registers directly, with no combinational path from any input.
- Sticky errors clear only on reset.
- Reset mid-chunk: indices drop to 0 and the consumer sees an empty ring immediately. Any in-flight consumer read returns don't-care data.

Optional Feature:
- Macro: C2F_FILL_CHECK_EN.
- Defined:
  - A per-chunk bitmap of CHUNK_QWORDS bits records accepted writes.
  - A doorbell is accepted only if the bitmap of chunk wrIndex is all ones.
  - If the bitmap is incomplete: wrIndex holds and fillErr_out is set.
  - The chunk bitmap clears when that chunk is committed.
  - Full takes priority: a full ring sets ovfErr_out only.
- Not defined: no bitmap; fillErr_out is tied to 0.

Test Plan:
- Reset, write QW k=1..16 to chunk 0 offsets 0..15, doorbell -> wrIndex_out=1, rdIndex_out=0. Reads at offsets 0..15 return 1..16, each one cycle later.
- Commit 3 chunks (NUM_CHUNKS=4), then a 4th doorbell -> wrIndex stays 3, ovfErr_out=1. dtAck plus doorbell in the same cycle -> rdIndex=1, wrIndex=0 (wrap), no new error.
- dtAck on an empty ring after reset -> rdIndex stays 0, udfErr_out=1. dtAck plus doorbell in the same cycle on empty -> wrIndex=1, rdIndex=0, udfErr_out=1.
- With chunk 0 committed, write 0xDEAD to {chunk 0, offset 3} -> dropped; wrErr_out=1; a read of offset 3 returns the original value. The same write to chunk 1 succeeds.
- Assert reset mid-operation with occupancy 2 and errors set -> all indices and flags read 0 in the same cycle (asynchronous).
- With C2F_FILL_CHECK_EN: write 15 of 16 QWs, then doorbell -> wrIndex holds, fillErr_out=1. Write the 16th QW, then doorbell -> wrIndex=1.
